// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register (skid buffer) with valid/ready on both
// sides. REG=1 gives a registered buffer with no combinational path between
// the two handshakes; REG=0 degenerates to a wire-through with CE/RST gating.
module pipe_skid_reg #(
  parameter int WIDTH = 18,
  parameter bit REG   = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             FLUSH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  generate
    if (REG) begin : g_reg
      // main_q is always the head of the queue; skid_q only holds the
      // second entry that arrived while the head was stalled.
      logic [WIDTH-1:0] main_q, main_d;
      logic [WIDTH-1:0] skid_q, skid_d;
      logic [1:0]       count_q, count_d;
      logic             push, pop;

      // Handshakes depend only on registered occupancy plus CE/RST.
      always_comb begin
        in_ready  = CE & ~RST & (count_q != 2'd2);
        out_valid = CE & ~RST & (count_q != 2'd0);
        out_data  = RST ? '0 : main_q;
        count     = count_q;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
      end

      // Next-state: RST beats FLUSH beats CE hold beats the normal update.
      always_comb begin
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = count_q;
        if (RST) begin
          main_d  = '0;
          skid_d  = '0;
          count_d = 2'd0;
        end else if (FLUSH) begin
          count_d = 2'd0;
        end else if (CE) begin
          case (count_q)
            2'd0: begin
              if (push) begin
                main_d  = in_data;
                count_d = 2'd1;
              end
            end
            2'd1: begin
              if (push && pop) begin
                main_d = in_data;
              end else if (push) begin
                skid_d  = in_data;
                count_d = 2'd2;
              end else if (pop) begin
                count_d = 2'd0;
              end
            end
            2'd2: begin
              if (pop) begin
                main_d  = skid_q;
                count_d = 2'd1;
              end
            end
            default: count_d = 2'd0;
          endcase
        end
      end

      // State registers; reset is folded into the next-state logic above.
      always_ff @(posedge CLK) begin
        main_q  <= main_d;
        skid_q  <= skid_d;
        count_q <= count_d;
      end
    end else begin : g_bypass
      // Clock and flush have no role in the pass-through variant.
      logic unused_bypass;
      assign unused_bypass = CLK ^ FLUSH;

      // Zero-latency pass-through, gated by CE and held off during reset.
      always_comb begin
        out_valid = in_valid & CE & ~RST;
        in_ready  = out_ready & CE & ~RST;
        out_data  = in_data;
        count     = 2'd0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed table-driven bench for the skid buffer plus a random bypass check.
module tb_pipe_skid_reg;

  localparam int W = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Registered instance signals
  logic         rst, ce, flush, iv, ordy;
  logic [W-1:0] din;
  logic         ir, ov;
  logic [W-1:0] dout;
  logic [1:0]   cnt;

  // Bypass instance signals
  logic         b_rst, b_ce, b_flush, b_iv, b_ordy;
  logic [W-1:0] b_din;
  logic         b_ir, b_ov;
  logic [W-1:0] b_dout;
  logic [1:0]   b_cnt;

  pipe_skid_reg #(.WIDTH(W), .REG(1'b1)) dut (
    .CLK(clk), .RST(rst), .CE(ce), .FLUSH(flush),
    .in_valid(iv), .in_ready(ir), .in_data(din),
    .out_valid(ov), .out_ready(ordy), .out_data(dout), .count(cnt)
  );

  pipe_skid_reg #(.WIDTH(W), .REG(1'b0)) dut_byp (
    .CLK(clk), .RST(b_rst), .CE(b_ce), .FLUSH(b_flush),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_din),
    .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_dout), .count(b_cnt)
  );

  typedef struct {
    logic         rst, ce, flush, iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         e_ir, e_ov;
    logic [W-1:0] e_od;
    logic         chk_od;
    logic [1:0]   e_cnt;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic r, input logic c, input logic f, input logic v,
                     input logic [W-1:0] d, input logic o, input logic eir,
                     input logic eov, input logic [W-1:0] eod, input logic chk,
                     input logic [1:0] ecnt);
    vec_t t;
    t.rst = r; t.ce = c; t.flush = f; t.iv = v; t.d = d; t.ordy = o;
    t.e_ir = eir; t.e_ov = eov; t.e_od = eod; t.chk_od = chk; t.e_cnt = ecnt;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  initial begin
    // rst ce fl iv data      ordy  ir ov data     chk cnt
    // Reset held two cycles with a pending push
    add(1, 1, 0, 1, 18'h155, 0,    0, 0, 18'h0,   1, 0);
    add(1, 1, 0, 1, 18'h155, 0,    0, 0, 18'h0,   1, 0);
    add(0, 1, 0, 0, 18'h0,   1,    1, 0, 18'h0,   0, 0);
    // Streaming 0x001..0x010 with out_ready high: one word per cycle
    for (int i = 1; i <= 16; i++)
      add(0, 1, 0, 1, W'(i), 1, 1, (i > 1), W'(i - 1), (i > 1), (i > 1) ? 2'd1 : 2'd0);
    add(0, 1, 0, 0, 18'h0,   1,    1, 1, 18'h010, 1, 1);
    add(0, 1, 0, 0, 18'h0,   1,    1, 0, 18'h0,   0, 0);
    // Backpressure: fill, hold 0x0A3 off, then drain in order
    add(0, 1, 0, 1, 18'h0A1, 0,    1, 0, 18'h0,   0, 0);
    add(0, 1, 0, 1, 18'h0A2, 0,    1, 1, 18'h0A1, 1, 1);
    add(0, 1, 0, 1, 18'h0A3, 0,    0, 1, 18'h0A1, 1, 2);
    add(0, 1, 0, 1, 18'h0A3, 0,    0, 1, 18'h0A1, 1, 2);
    add(0, 1, 0, 1, 18'h0A3, 0,    0, 1, 18'h0A1, 1, 2);
    add(0, 1, 0, 1, 18'h0A3, 1,    0, 1, 18'h0A1, 1, 2);
    add(0, 1, 0, 1, 18'h0A3, 1,    1, 1, 18'h0A2, 1, 1);
    add(0, 1, 0, 0, 18'h0,   1,    1, 1, 18'h0A3, 1, 1);
    add(0, 1, 0, 0, 18'h0,   1,    1, 0, 18'h0,   0, 0);
    // CE stall with one entry held
    add(0, 1, 0, 1, 18'h077, 0,    1, 0, 18'h0,   0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 1, 18'h0EE, 1,  0, 0, 18'h077, 1, 1);
    add(0, 1, 0, 0, 18'h0,   1,    1, 1, 18'h077, 1, 1);
    add(0, 1, 0, 0, 18'h0,   1,    1, 0, 18'h0,   0, 0);
    // Flush a full buffer while a push is offered
    add(0, 1, 0, 1, 18'h111, 0,    1, 0, 18'h0,   0, 0);
    add(0, 1, 0, 1, 18'h222, 0,    1, 1, 18'h111, 1, 1);
    add(0, 1, 1, 1, 18'h333, 0,    0, 1, 18'h111, 1, 2);
    add(0, 1, 0, 1, 18'h444, 1,    1, 0, 18'h0,   0, 0);
    add(0, 1, 0, 0, 18'h0,   1,    1, 1, 18'h444, 1, 1);
    add(0, 1, 0, 0, 18'h0,   1,    1, 0, 18'h0,   0, 0);

    // Bypass instance idles in reset while the table runs
    b_rst = 1; b_ce = 1; b_flush = 0; b_iv = 0; b_ordy = 0; b_din = '0;

    // One unchecked reset edge so the state is defined
    rst = 1; ce = 1; flush = 0; iv = 0; din = '0; ordy = 0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; ce = vecs[i].ce; flush = vecs[i].flush;
      iv = vecs[i].iv; din = vecs[i].d; ordy = vecs[i].ordy;
      #1;
      chk("in_ready", i, 32'(ir), 32'(vecs[i].e_ir));
      chk("out_valid", i, 32'(ov), 32'(vecs[i].e_ov));
      chk("count", i, 32'(cnt), 32'(vecs[i].e_cnt));
      if (vecs[i].chk_od)
        chk("out_data", i, 32'(dout), 32'(vecs[i].e_od));
      $display("vec %0d: rst=%0d ce=%0d fl=%0d iv=%0d d=%0h ordy=%0d -> ir=%0d ov=%0d od=%0h cnt=%0d",
               i, rst, ce, flush, iv, din, ordy, ir, ov, dout, cnt);
      @(posedge clk); #1;
    end

    // Bypass: reset gating, then random traffic against a zero-latency model
    b_rst = 1; b_ce = 1; b_iv = 1; b_ordy = 1; b_din = 18'h155;
    #1;
    chk("byp_rst_out_valid", 0, 32'(b_ov), 32'd0);
    chk("byp_rst_in_ready", 0, 32'(b_ir), 32'd0);
    @(posedge clk); #1;
    b_rst = 0;
    for (int i = 0; i < 40; i++) begin
      logic         e_ov, e_ir;
      logic [W-1:0] e_od;
      b_iv    = 1'($urandom_range(0, 1));
      b_ordy  = 1'($urandom_range(0, 1));
      b_ce    = ($urandom_range(0, 7) != 0);
      b_flush = 1'($urandom_range(0, 1));
      b_din   = W'($urandom);
      e_ov = b_iv & b_ce;
      e_ir = b_ordy & b_ce;
      e_od = b_din;
      #1;
      chk("byp_out_valid", i, 32'(b_ov), 32'(e_ov));
      chk("byp_in_ready", i, 32'(b_ir), 32'(e_ir));
      chk("byp_out_data", i, 32'(b_dout), 32'(e_od));
      chk("byp_count", i, 32'(b_cnt), 32'd0);
      $display("byp %0d: iv=%0d ordy=%0d ce=%0d d=%0h -> ov=%0d ir=%0d od=%0h",
               i, b_iv, b_ordy, b_ce, b_din, b_ov, b_ir, b_dout);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Two-entry elastic pipeline register (skid buffer) with a valid/ready handshake on both sides.
- It is the consumer-facing counterpart of the enable/bypass pipeline registers in the DSP48A1 datapath: a stage downstream can stall it via backpressure without losing data or adding a bubble.
- Sits between DSP48A1 pipeline stages and any downstream reader, e.g. the P output feeding a stall-capable sink.

Parameters:
- WIDTH, 18, data bus width in bits.
- REG, 1, 1 = registered skid buffer; 0 = combinational pass-through.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- CE  input  1  clock enable; when 0, holds all state and blocks both handshakes.
- FLUSH  input  1  synchronous discard of all stored entries.
- in_valid  input  1  upstream has data on in_data.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  head-of-buffer data.
- count  output  2  number of stored entries (0..2).

Behaviour:
- Push = in_valid & in_ready at the CLK edge. Pop = out_valid & out_ready at the CLK edge.
- Storage: main register (always drives out_data) and skid register; count register.
- in_ready = CE & ~RST & (count != 2).
- out_valid = CE & ~RST & (count != 0).
- These are combinational from registered state, CE and RST only. No combinational path from in_valid to out_valid or from out_ready to in_ready.
- Priority at each edge: RST > FLUSH > ~CE (hold) > normal update.
- RST=1: count=0, main=0, skid=0. While RST is high, in_ready=0, out_valid=0, out_data=0.
- FLUSH=1 (RST=0): count=0; data registers keep their old values and are don't-care. A push presented in that cycle is dropped.
- CE=0: no state change. in_ready and out_valid are forced to 0, so no transfer is counted.
- EMPTY (count=0):
  - push -> main<=in_data, count=1.
  - A pop is impossible because out_valid=0.
- ONE (count=1):
  - push & pop -> main<=in_data, count stays 1 (full throughput, zero bubbles).
  - push only -> skid<=in_data, count=2.
  - pop only -> count=0.
  - neither -> hold.
- FULL (count=2):
  - pop -> main<=skid, count=1.
  - No push is possible because in_ready=0.
  - in_ready deasserts the cycle after the second entry is stored.
- Order is strict FIFO: skid data is never emitted before main data.
- Latency (REG=1): 1 cycle from push to out_valid when empty. Sustained throughput is 1 word/cycle when out_ready=1.
- count is registered; count=3 is unreachable.
- REG=0:
  - out_valid = in_valid & CE; in_ready = out_ready & CE; out_data = in_data.
  - count=0 at all times; FLUSH has no effect.
  - While RST=1, out_valid=0 and in_ready=0.
- Data bits are passed unmodified; there is no width conversion.

Test Plan:
- Reset/idle: RST=1 for 2 cycles with in_valid=1, in_data=18'h155 -> in_ready=0, out_valid=0, out_data=0, count=0. After RST falls, in_ready=1 and count=0.
- Streaming: CE=1, out_ready=1, push 0x001..0x010 on consecutive cycles -> out_data emits 0x001..0x010 starting 1 cycle after the first push, one per cycle, count stays 1, no bubbles.
- Backpressure:
  - out_ready=0, push 0x0A1 then 0x0A2 -> count=2, in_ready=0, out_data=0x0A1.
  - Hold in_valid=1 with 0x0A3 for 3 cycles -> not accepted.
  - Raise out_ready -> outputs 0x0A1, 0x0A2, 0x0A3 in order.
- CE stall: with count=1 (head 0x077), set CE=0 for 4 cycles with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, count=1, no transfer. Restore CE -> 0x077 is popped first.
- Flush:
  - Fill to count=2 (0x111, 0x222), then assert FLUSH one cycle with in_valid=1, in_data=0x333 -> count=0, out_valid=0, 0x333 dropped.
  - Next push 0x444 -> 0x444 is the first output.
- Bypass (REG=0): toggle in_valid and out_ready randomly -> out_data==in_data, out_valid==in_valid, in_ready==out_ready every cycle, count=0. Scoreboard matches a zero-latency model.
